// File: rtl/sd_pkg.sv
// Shared encodings for the SD card init sequencer: states, command steps,
// command indices/arguments, R1 codes and failure causes.
package sd_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_PWRUP, S_CRC, S_SEND, S_WAIT, S_READY, S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    STEP_CMD0, STEP_CMD8, STEP_CMD55, STEP_ACMD41, STEP_CMD58
  } step_t;

  localparam logic [5:0]  IDX_CMD0   = 6'd0;
  localparam logic [5:0]  IDX_CMD8   = 6'd8;
  localparam logic [5:0]  IDX_CMD55  = 6'd55;
  localparam logic [5:0]  IDX_ACMD41 = 6'd41;
  localparam logic [5:0]  IDX_CMD58  = 6'd58;

  localparam logic [31:0] ARG_CMD0   = 32'h0000_0000;
  localparam logic [31:0] ARG_CMD8   = 32'h0000_01AA;
  localparam logic [31:0] ARG_CMD55  = 32'h0000_0000;
  localparam logic [31:0] ARG_ACMD41 = 32'h4000_0000;
  localparam logic [31:0] ARG_CMD58  = 32'h0000_0000;

  localparam logic [7:0]  R1_READY = 8'h00;
  localparam logic [7:0]  R1_IDLE  = 8'h01;

  localparam logic [2:0]  ERR_NONE    = 3'd0;
  localparam logic [2:0]  ERR_CMD0    = 3'd1;
  localparam logic [2:0]  ERR_CMD8    = 3'd2;
  localparam logic [2:0]  ERR_CMD55   = 3'd3;
  localparam logic [2:0]  ERR_ACMD41  = 3'd4;
  localparam logic [2:0]  ERR_CMD58   = 3'd5;
  localparam logic [2:0]  ERR_TIMEOUT = 3'd6;

  // Upper 40 bits of the frame: start/transmission bits, index, argument.
  function automatic logic [39:0] cmd_header(step_t s);
    logic [39:0] h;
    unique case (s)
      STEP_CMD8:   h = {2'b01, IDX_CMD8,   ARG_CMD8};
      STEP_CMD55:  h = {2'b01, IDX_CMD55,  ARG_CMD55};
      STEP_ACMD41: h = {2'b01, IDX_ACMD41, ARG_ACMD41};
      STEP_CMD58:  h = {2'b01, IDX_CMD58,  ARG_CMD58};
      default:     h = {2'b01, IDX_CMD0,   ARG_CMD0};
    endcase
    return h;
  endfunction

endpackage

// File: rtl/sd_init_seq_if.sv
// Command/response handshake between the init sequencer and the SD controller.
interface sd_init_seq_if;
  logic [47:0] sd_cmd;
  logic        sd_start;
  logic        sd_resp_valid;
  logic [7:0]  sd_resp;

  modport master (output sd_cmd, sd_start, input sd_resp_valid, sd_resp);
  modport slave  (input sd_cmd, sd_start, output sd_resp_valid, sd_resp);
endinterface

// File: rtl/sd_crc7.sv
// Serial CRC-7 (x^7 + x^3 + 1, init 0), one message bit per enabled cycle.
module sd_crc7 (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       en,
  input  logic       bit_in,
  output logic [6:0] crc
);
  logic fb;
  assign fb = bit_in ^ crc[6];

  always_ff @(posedge clk) begin
    if (!resetn)     crc <= '0;
    else if (clear)  crc <= '0;
    else if (en)     crc <= {crc[5:0], 1'b0} ^ ({7{fb}} & 7'h09);
  end
endmodule

// File: rtl/sd_init_seq.sv
// SD card init sequencer: power-up wait, CMD0, CMD8, CMD55/ACMD41 polling, CMD58.
// state | meaning: IDLE idle, PWRUP power-up wait, CRC frame CRC, SEND latch frame, WAIT await R1, READY done, ERROR failed
module sd_init_seq
  import sd_pkg::*;
#(
  parameter int POWERUP_WAIT = 80,
  parameter int RESP_TIMEOUT = 1024,
  parameter int ACMD41_TRIES = 255
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          go,
  sd_init_seq_if.master sd_bus,
  output logic          busy,
  output logic          card_ready,
  output logic          init_error,
  output logic [2:0]    err_code
);
  localparam logic [7:0]  PWR_LAST  = 8'(POWERUP_WAIT - 1);
  localparam logic [10:0] TO_LAST   = 11'(RESP_TIMEOUT - 1);
  localparam logic [8:0]  TRIES_MAX = 9'(ACMD41_TRIES);

  state_t      state, state_n;
  step_t       step, step_n;
  logic [2:0]  err_n;
  logic [7:0]  tries, tries_n, tries_inc;
  logic [7:0]  pwr_cnt;
  logic [10:0] to_cnt;
  logic [5:0]  bit_cnt;
  logic [39:0] hdr;
  logic [6:0]  crc;
  logic        crc_clear, crc_en;
  logic        r1_idle, r1_ready;

  assign hdr      = cmd_header(step);
  assign r1_idle  = sd_bus.sd_resp == R1_IDLE;
  assign r1_ready = sd_bus.sd_resp == R1_READY;

  sd_crc7 u_crc7 (
    .clk    (clk),
    .resetn (resetn),
    .clear  (crc_clear),
    .en     (crc_en),
    .bit_in (hdr[6'd39 - bit_cnt]),
    .crc    (crc)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      step     <= STEP_CMD0;
      err_code <= ERR_NONE;
      tries    <= '0;
    end else begin
      state    <= state_n;
      step     <= step_n;
      err_code <= err_n;
      tries    <= tries_n;
    end
  end

  always_comb begin
    state_n   = state;
    step_n    = step;
    err_n     = err_code;
    tries_n   = tries;
    tries_inc = (tries == 8'hFF) ? tries : tries + 8'd1;
    case (state)
      S_IDLE, S_READY, S_ERROR:
        if (go) begin
          state_n = S_PWRUP;
          step_n  = STEP_CMD0;
          err_n   = ERR_NONE;
          tries_n = '0;
        end
      S_PWRUP: if (pwr_cnt == PWR_LAST) state_n = S_CRC;
      S_CRC:   if (bit_cnt == 6'd39)    state_n = S_SEND;
      S_SEND:  state_n = S_WAIT;
      S_WAIT:
        // A response on the timeout cycle still counts.
        if (sd_bus.sd_resp_valid) begin
          state_n = S_CRC;
          case (step)
            STEP_CMD0:
              if (r1_idle) step_n = STEP_CMD8;
              else begin state_n = S_ERROR; err_n = ERR_CMD0; end
            STEP_CMD8:
              if (r1_idle) step_n = STEP_CMD55;
              else begin state_n = S_ERROR; err_n = ERR_CMD8; end
            STEP_CMD55:
              if (r1_idle || r1_ready) step_n = STEP_ACMD41;
              else begin state_n = S_ERROR; err_n = ERR_CMD55; end
            STEP_ACMD41: begin
              tries_n = tries_inc;
              if (r1_ready) step_n = STEP_CMD58;
              else if (r1_idle && ({1'b0, tries_inc} < TRIES_MAX)) step_n = STEP_CMD55;
              else begin state_n = S_ERROR; err_n = ERR_ACMD41; end
            end
            default:
              if (r1_idle || r1_ready) state_n = S_READY;
              else begin state_n = S_ERROR; err_n = ERR_CMD58; end
          endcase
        end else if (to_cnt == TO_LAST) begin
          state_n = S_ERROR;
          err_n   = ERR_TIMEOUT;
        end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy            = 1'b1;
    card_ready      = 1'b0;
    init_error      = 1'b0;
    sd_bus.sd_start = 1'b0;
    crc_clear       = !(state == S_CRC || state == S_SEND);
    crc_en          = state == S_CRC;
    case (state)
      S_IDLE:  busy = 1'b0;
      S_READY: begin busy = 1'b0; card_ready = 1'b1; end
      S_ERROR: begin busy = 1'b0; init_error = 1'b1; end
      S_WAIT:  sd_bus.sd_start = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pwr_cnt       <= '0;
      bit_cnt       <= '0;
      to_cnt        <= '0;
      sd_bus.sd_cmd <= '0;
    end else begin
      if (state != S_PWRUP)     pwr_cnt <= '0;
      else if (pwr_cnt != '1)   pwr_cnt <= pwr_cnt + 8'd1;
      bit_cnt <= (state == S_CRC) ? bit_cnt + 6'd1 : '0;
      if (state != S_WAIT)      to_cnt <= '0;
      else if (to_cnt != '1)    to_cnt <= to_cnt + 11'd1;
      if (state == S_SEND)      sd_bus.sd_cmd <= {hdr, crc, 1'b1};
    end
  end
endmodule

// File: tb/tb_sd_init_seq.sv
// Randomized bench for sd_init_seq against a transaction-timeline model of the init sequence.
module tb_sd_init_seq;
  localparam int P     = 8;
  localparam int TO    = 16;
  localparam int TRIES = 3;

  localparam logic [47:0] F_CMD0   = 48'h400000000095;
  localparam logic [47:0] F_CMD8   = 48'h48000001AA87;
  localparam logic [47:0] F_CMD55  = 48'h770000000065;
  localparam logic [47:0] F_ACMD41 = 48'h694000000077;
  localparam logic [47:0] F_CMD58  = 48'h7A00000000FD;

  logic       clk = 1'b0;
  logic       resetn, go;
  logic       busy, card_ready, init_error;
  logic [2:0] err_code;

  always #5 clk = ~clk;

  sd_init_seq_if sd_bus ();

  sd_init_seq #(.POWERUP_WAIT(P), .RESP_TIMEOUT(TO), .ACMD41_TRIES(TRIES)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .go         (go),
    .sd_bus     (sd_bus),
    .busy       (busy),
    .card_ready (card_ready),
    .init_error (init_error),
    .err_code   (err_code)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: expected outputs derived from the sequence rules and cycle timeline.
  bit          m_busy, m_ready, m_error, m_waiting;
  int          m_err, m_countdown, m_wait_cycles, m_cmd, m_tries;
  logic [47:0] m_frame;
  bit          chk_en = 1'b0;

  function automatic logic [47:0] frame_of(input int idx);
    logic [31:0] arg;
    logic [39:0] h;
    logic [46:0] rem;
    arg = (idx == 8) ? 32'h1AA : (idx == 41) ? 32'h40000000 : 32'h0;
    h   = {2'b01, 6'(idx), arg};
    rem = {h, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (rem[i]) rem[i -: 8] = rem[i -: 8] ^ 8'h89;
    return {h, rem[6:0], 1'b1};
  endfunction

  task automatic next_cmd(input int c);
    m_cmd = c;
    m_countdown = 41;
  endtask

  task automatic give_up(input int e);
    m_busy = 0; m_error = 1; m_err = e;
  endtask

  task automatic judge(input logic [7:0] r);
    case (m_cmd)
      0:  if (r == 8'h01) next_cmd(8);  else give_up(1);
      8:  if (r == 8'h01) next_cmd(55); else give_up(2);
      55: if (r <= 8'h01) next_cmd(41); else give_up(3);
      41: begin
        if (m_tries < 255) m_tries++;
        if (r == 8'h00) next_cmd(58);
        else if (r == 8'h01 && m_tries < TRIES) next_cmd(55);
        else give_up(4);
      end
      default: if (r <= 8'h01) begin m_busy = 0; m_ready = 1; end else give_up(5);
    endcase
  endtask

  task automatic model_step(input bit g, input bit rv, input logic [7:0] r, input bit rstn);
    if (!rstn) begin
      m_busy = 0; m_ready = 0; m_error = 0; m_err = 0; m_waiting = 0; m_countdown = 0;
    end else if (!m_busy) begin
      if (g) begin
        m_busy = 1; m_ready = 0; m_error = 0; m_err = 0;
        m_cmd = 0; m_tries = 0; m_countdown = P + 41;
      end
    end else if (m_waiting) begin
      if (rv) begin
        m_waiting = 0;
        judge(r);
      end else begin
        m_wait_cycles++;
        if (m_wait_cycles == TO) begin m_waiting = 0; give_up(6); end
      end
    end else begin
      m_countdown--;
      if (m_countdown == 0) begin
        m_waiting = 1; m_wait_cycles = 0; m_frame = frame_of(m_cmd);
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("sd_start",   48'(sd_bus.sd_start), 48'(m_waiting));
      chk("busy",       48'(busy),            48'(m_busy));
      chk("card_ready", 48'(card_ready),      48'(m_ready));
      chk("init_error", 48'(init_error),      48'(m_error));
      if (m_error)   chk("err_code", 48'(err_code), 48'(m_err));
      if (m_waiting) chk("sd_cmd", sd_bus.sd_cmd, m_frame);
    end
  end

  // Stimulus
  logic [7:0]  rq[$];
  int          dq[$];
  logic [47:0] obs[$];
  int          hi_cnt;
  bit          noise, rand_to;

  task automatic drive_edge(input bit g, input bit rv, input logic [7:0] r, input bit rstn);
    go = g; sd_bus.sd_resp_valid = rv; sd_bus.sd_resp = r; resetn = rstn;
    @(posedge clk);
    model_step(g, rv, r, rstn);
  endtask

  function automatic int pick_delay();
    if (dq.size() > 0) return dq.pop_front();
    return rand_to ? int'($urandom_range(0, 18)) : int'($urandom_range(0, 12));
  endfunction

  function automatic logic [7:0] pick_resp();
    if (rq.size() > 0) return rq.pop_front();
    if ($urandom_range(0, 9) == 0) return 8'($urandom);
    if (m_cmd == 0 || m_cmd == 8) return 8'h01;
    return 8'($urandom_range(0, 1));
  endfunction

  task automatic run_seq(input int budget, input int rst_frame);
    int wctr = 0, tgt = 0, nrise = 0;
    bit prev = 0, rv, g, rstn;
    logic [7:0] rb;
    obs.delete();
    hi_cnt = 0;
    @(negedge clk);
    drive_edge(1, 0, 8'h00, 1);
    for (int k = 0; k < budget && m_busy; k++) begin
      @(negedge clk);
      rv = 0; g = 0; rstn = 1; rb = 8'($urandom);
      if (sd_bus.sd_start) begin
        hi_cnt++;
        if (!prev) begin
          obs.push_back(sd_bus.sd_cmd);
          nrise++; wctr = 0; tgt = pick_delay();
        end
        if (nrise == rst_frame && wctr == 2) rstn = 0;
        else if (wctr == tgt) begin rv = 1; rb = pick_resp(); end
        wctr++;
      end else if (noise && $urandom_range(0, 7) == 0) rv = 1;
      if (noise && rstn && $urandom_range(0, 15) == 0) g = 1;
      prev = sd_bus.sd_start;
      drive_edge(g, rv, rb, rstn);
    end
    if (m_busy) begin
      checks++; errors++;
      $display("FAIL run_budget actual=busy required=done within %0d cycles", budget);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive_edge(0, 0, 8'h00, 1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    resetn = 0; go = 0; sd_bus.sd_resp_valid = 0; sd_bus.sd_resp = 8'h00;
    noise = 0; rand_to = 0;
    repeat (3) begin @(negedge clk); drive_edge(0, 0, 8'h00, 0); end
    @(negedge clk);
    chk("rst_sd_cmd",     sd_bus.sd_cmd,        48'h0);
    chk("rst_sd_start",   48'(sd_bus.sd_start), 48'h0);
    chk("rst_busy",       48'(busy),            48'h0);
    chk("rst_card_ready", 48'(card_ready),      48'h0);
    chk("rst_init_error", 48'(init_error),      48'h0);
    chk("rst_err_code",   48'(err_code),        48'h0);
    drive_edge(0, 0, 8'h00, 1);
    chk_en = 1;

    chk("model_frame_cmd0",   frame_of(0),  F_CMD0);
    chk("model_frame_cmd8",   frame_of(8),  F_CMD8);
    chk("model_frame_cmd55",  frame_of(55), F_CMD55);
    chk("model_frame_acmd41", frame_of(41), F_ACMD41);
    chk("model_frame_cmd58",  frame_of(58), F_CMD58);

    // Happy path, last response lands on the timeout cycle.
    rq = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00};
    dq = '{3, 0, 7, 1, 2, 5, 15};
    run_seq(3000, 0);
    idle(2);
    chk("happy_frame_count", 48'(obs.size()), 48'd7);
    if (obs.size() == 7) begin
      chk("happy_f0", obs[0], F_CMD0);
      chk("happy_f1", obs[1], F_CMD8);
      chk("happy_f2", obs[2], F_CMD55);
      chk("happy_f3", obs[3], F_ACMD41);
      chk("happy_f4", obs[4], F_CMD55);
      chk("happy_f5", obs[5], F_ACMD41);
      chk("happy_f6", obs[6], F_CMD58);
    end
    @(negedge clk);
    chk("happy_card_ready", 48'(card_ready), 48'h1);
    chk("happy_busy",       48'(busy),       48'h0);
    drive_edge(0, 0, 8'h00, 1);

    // ACMD41 never leaves idle.
    rq = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    run_seq(3000, 0);
    cnt = 0;
    foreach (obs[i]) if (obs[i][45:40] == 6'd41) cnt++;
    chk("acmd41_frames", 48'(cnt), 48'd3);
    @(negedge clk);
    chk("acmd41_init_error", 48'(init_error), 48'h1);
    chk("acmd41_err_code",   48'(err_code),   48'd4);
    drive_edge(0, 0, 8'h00, 1);

    // Bad CMD0 response, then the bus must stay quiet.
    rq = '{8'h05};
    run_seq(3000, 0);
    hi_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sd_bus.sd_start) hi_cnt++;
      drive_edge(0, 0, 8'h00, 1);
    end
    chk("cmd0_no_more_start", 48'(hi_cnt), 48'd0);
    @(negedge clk);
    chk("cmd0_err_code", 48'(err_code), 48'd1);
    drive_edge(0, 0, 8'h00, 1);

    // Silent card.
    dq = '{40};
    run_seq(3000, 0);
    chk("timeout_start_cycles", 48'(hi_cnt), 48'd16);
    @(negedge clk);
    chk("timeout_err_code", 48'(err_code), 48'd6);
    drive_edge(0, 0, 8'h00, 1);

    // Reset during the CMD8 wait, then restart.
    rq = '{8'h01};
    dq = '{4, 10};
    run_seq(3000, 2);
    @(negedge clk);
    chk("midrst_sd_start", 48'(sd_bus.sd_start), 48'h0);
    chk("midrst_busy",     48'(busy),            48'h0);
    chk("midrst_sd_cmd",   sd_bus.sd_cmd,        48'h0);
    drive_edge(0, 0, 8'h00, 1);
    dq.delete();
    rq = '{8'h05};
    run_seq(3000, 0);
    chk("midrst_restart_frames", 48'(obs.size()), 48'd1);
    if (obs.size() > 0) chk("midrst_restart_cmd0", obs[0], F_CMD0);
    idle(2);

    // Randomized responses, delays, timeouts and stray inputs.
    rq.delete(); dq.delete();
    noise = 1; rand_to = 1;
    repeat (30) begin
      run_seq(3000, 0);
      idle(3);
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sd_init_seq.md
SD_INIT_SEQ -- requirements
Module: sd_init_seq

Interface
REQ-001 The block SHALL have parameter POWERUP_WAIT, default 80, giving the number of clk cycles to wait after go before CMD0.
REQ-002 The block SHALL have parameter RESP_TIMEOUT, default 1024, giving the maximum clk cycles from sd_start rise to sd_resp_valid.
REQ-003 The block SHALL have parameter ACMD41_TRIES, default 255, giving the maximum number of CMD55+ACMD41 pairs.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-005 The block SHALL have port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port go, input, 1 bit: a one-cycle pulse that starts the init sequence.
REQ-007 The block SHALL have port sd_cmd, output, 48 bits: the command frame to SDController cmd.
REQ-008 The block SHALL have port sd_start, output, 1 bit: the start level to SDController start.
REQ-009 The block SHALL have port sd_resp_valid, input, 1 bit: the SDController responseByte pulse.
REQ-010 The block SHALL have port sd_resp, input, 8 bits: the SDController R1 response byte.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE, READY and ERROR.
REQ-012 The block SHALL have port card_ready, output, 1 bit: a level, high in READY.
REQ-013 The block SHALL have port init_error, output, 1 bit: a level, high in ERROR.
REQ-014 The block SHALL have port err_code, output, 3 bits: the failure cause, valid while init_error is high.

Function
REQ-015 States SHALL be IDLE, PWRUP, CRC, SEND, WAIT, READY and ERROR; command step SHALL be CMD0, CMD8, CMD55, ACMD41, CMD58.
REQ-016 In IDLE, READY or ERROR, go SHALL enter PWRUP, clear the counters and set step=CMD0; go SHALL be ignored while busy.
REQ-017 PWRUP SHALL count POWERUP_WAIT cycles, then enter CRC.
REQ-018 Frame SHALL be {2'b01, index[5:0], arg[31:0], crc7[6:0], 1'b1}, with crc7 being CRC-7 (x^7+x^3+1, init 0) over the upper 40 bits.
REQ-019 CRC SHALL shift the 40 bits MSB-first, one bit per cycle (40 cycles), then latch sd_cmd and enter SEND.
REQ-020 Arguments SHALL be: CMD0 0x00000000; CMD8 0x000001AA; CMD55 0x00000000; ACMD41 (index 41) 0x40000000; CMD58 0x00000000.
REQ-021 SEND SHALL raise sd_start, reset the timeout counter and enter WAIT.
REQ-022 sd_start SHALL stay high throughout WAIT and drop on the clk edge on which sd_resp_valid is sampled, or on timeout.
REQ-023 sd_cmd SHALL remain stable from the SEND edge until WAIT exits.
REQ-024 WAIT SHALL check the response as follows: CMD0 requires 0x01, else err 1; CMD8 requires 0x01, else err 2; CMD55 accepts 0x00 or 0x01, else err 3.
REQ-025 For ACMD41, 0x00 SHALL go to CMD58; 0x01 SHALL retry CMD55 if tries < ACMD41_TRIES, else err 4; any other value SHALL give err 4.
REQ-026 For CMD58, 0x00 or 0x01 SHALL go to READY; any other value SHALL give err 5.
REQ-027 A passing response SHALL advance step and enter CRC.
REQ-028 An ACMD41 try SHALL be counted when the ACMD41 response is sampled.
REQ-029 If RESP_TIMEOUT cycles elapse in WAIT without sd_resp_valid, the block SHALL enter ERROR with err 6; if timeout and sd_resp_valid coincide, the response SHALL win.
REQ-030 sd_resp_valid outside WAIT SHALL be ignored.
REQ-031 Counters SHALL saturate and never wrap: timeout 11 bits, tries 8 bits, power-up 8 bits.

Reset
REQ-032 On a clk edge with resetn=0, the block SHALL reset to: state IDLE, sd_start 0, sd_cmd 0, busy 0, card_ready 0, init_error 0, err_code 0, all counters and the CRC register 0.
REQ-033 Reset mid-sequence SHALL drop sd_start on that same edge; no partial command SHALL resume.

Structure
REQ-034 Shared package sd_pkg SHALL hold the command indices, arguments, state encoding and err_code values.
REQ-035 The block SHALL have one sub-module, sd_crc7, a serial CRC-7 with clear, enable, bit-in and crc[6:0].

Verification
REQ-036 Frame values SHALL be exact: CMD0=0x400000000095, CMD8=0x48000001AA87, CMD55=0x770000000065, ACMD41=0x694000000077, CMD58=0x7A00000000FD.
REQ-037 Happy path: responses 01,01,01,01,01,00,00 -> CMD0, CMD8, 2x(CMD55, ACMD41), CMD58 issued, then card_ready=1 and busy=0.
REQ-038 ACMD41 always returns 0x01 with ACMD41_TRIES=3 -> exactly 3 ACMD41 frames, then init_error=1 and err_code=4.
REQ-039 CMD0 response 0x05 -> ERROR with err_code=1 and no further sd_start.
REQ-040 No sd_resp_valid for RESP_TIMEOUT=16 -> err_code=6, with sd_start low after exactly 16 WAIT cycles.
REQ-041 resetn low during CMD8 WAIT -> sd_start=0 next edge and state IDLE; go then -> sequence restarts at CMD0.
